prime_verify_multi: RTL and testbench
=====================================

// Module: prime_verify_multi
// PURPOSE
//  Multi-player round verifier for the prime-prediction game.
//  - Captures which player(s) claimed "prime" on the current number.
//  - Checks the claim against the adder/prime-check flag and pulses a per-player win or miss.
//  - Keeps saturating per-player scores.
//  - Holds off new claims until the RNG signals the next number, or until a timeout expires.
//  - Sits between the player input logic, the prime/adder checker and the score display.
// PARAMETERS
//  N_PLY      2    number of players (1..8)
//  SCORE_W    4    width of each player's score counter
//  TIMEOUT    16   HOLD-state cycles before forced return to IDLE; 0 = wait for rng forever
//  MULTI_WIN  1    1 = all simultaneous claimants captured; 0 = lowest-index claimant only
// PORTS
//  clk          in   1              clock, rising edge
//  rst          in   1              synchronous reset, active-low
//  rng          in   1              next-number strobe from the RNG
//  ply_req      in   N_PLY          per-player claim, level-sampled
//  adder        in   1              prime flag for the current number
//  score_clr    in   1              synchronous clear of all scores
//  verify_out   out  N_PLY          1-cycle pulse per winning player
//  miss_out     out  N_PLY          1-cycle pulse per wrong claimant
//  timeout      out  1              1-cycle pulse on HOLD timeout
//  busy         out  1              high when state != IDLE
//  score        out  N_PLY*SCORE_W  packed scores; player i at [i*SCORE_W +: SCORE_W]
// BEHAVIOUR
//  Reset (rst==0 at a clk edge)
//   - state=IDLE; claim mask, timer and all scores = 0.
//   - verify_out, miss_out, timeout = 0; busy = 0.
//   - Takes effect from any state, mid-round included.
//  IDLE
//   - Outputs verify_out, miss_out and timeout = 0.
//   - If |ply_req: capture mask (all set bits, or the lowest set bit when MULTI_WIN=0) -> EVAL.
//   - rng is ignored in IDLE.
//  EVAL (exactly one cycle; adder sampled here)
//   - adder==1: verify_out<=mask; score[i]+=1 for each set mask bit, saturating at 2^SCORE_W-1; -> IDLE.
//   - adder==0: miss_out<=mask; clear timer; -> HOLD.
//  HOLD
//   - Pulse outputs return to 0.
//   - rng==1 -> IDLE, with priority over timeout in the same cycle.
//   - Otherwise, if TIMEOUT!=0 and timer==TIMEOUT-1: timeout<=1, -> IDLE.
//   - Otherwise timer+=1.
//  Latency
//   - ply_req sampled at edge k; adder sampled at edge k+1.
//   - verify_out or miss_out is high for one cycle after edge k+1.
//  ply_req while in EVAL or HOLD is ignored and not queued.
//  score_clr zeroes all scores; a same-cycle increment is dropped (clear wins).
//  All outputs are registered; no combinational input-to-output path.
//  Timer width: $clog2(TIMEOUT+1), minimum 1.
// STRUCTURE
//  prime_pred_pkg
//   - State encoding: S_IDLE=0, S_EVAL=1, S_HOLD=2 (2-bit).
//   - MAX_PLY=8 constant.
//  Sub-module sat_counter #(W) (clr, inc, q): one instance per player via generate.
//  FSM, claim mask, priority pick and timer live in this top level.
// TESTING
//  1. ply_req=01, adder=1 at EVAL -> verify_out=01 for 1 cycle; score0=1; back in IDLE 2 cycles after claim.
//  2. ply_req=11 with MULTI_WIN=1, adder=1 -> verify_out=11; both scores +1. Same with MULTI_WIN=0 -> verify_out=01.
//  3. ply_req=10, adder=0 -> miss_out=10; busy stays high; rng pulse 3 cycles later -> IDLE; a new claim is then accepted.
//  4. Miss, no rng, TIMEOUT=16 -> timeout pulses exactly 16 cycles after HOLD entry; ply_req held during HOLD is ignored.
//  5. SCORE_W=4: 16 consecutive wins by player0 -> score0 stays 15. score_clr together with a win -> score0=0.
//  6. rst=0 asserted during HOLD -> next cycle: IDLE, all outputs 0, scores 0; rng and timeout at the same edge -> IDLE with timeout=0.

Source files
------------

// File: rtl/prime_verify_multi_pkg.sv
// Shared types and constants for the prime-prediction game verifier.
// State encoding is fixed so other blocks and debug tooling can decode it.
package prime_pred_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam int MAX_PLY = 8;

endpackage

// File: rtl/prime_verify_multi_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      q_reg <= '0;
    end else if (inc && (q_reg != {W{1'b1}})) begin
      q_reg <= q_reg + 1'b1;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/prime_verify_multi.sv
// Multi-player round verifier: captures prime claims, checks them against the
// prime flag one cycle later, pulses win/miss, and keeps per-player scores.
module prime_verify_multi
  import prime_pred_pkg::*;
#(
  parameter int N_PLY     = 2,
  parameter int SCORE_W   = 4,
  parameter int TIMEOUT   = 16,
  parameter int MULTI_WIN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rng,
  input  logic [N_PLY-1:0]         ply_req,
  input  logic                     adder,
  input  logic                     score_clr,
  output logic [N_PLY-1:0]         verify_out,
  output logic [N_PLY-1:0]         miss_out,
  output logic                     timeout,
  output logic                     busy,
  output logic [N_PLY*SCORE_W-1:0] score
);

  localparam int TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [N_PLY-1:0] mask_reg, mask_next;
  logic [N_PLY-1:0] verify_reg, verify_next;
  logic [N_PLY-1:0] miss_reg, miss_next;
  logic             timeout_reg, timeout_next;
  logic [TW-1:0]    timer_reg, timer_next;
  logic [N_PLY-1:0] pick_low;
  logic             timer_hit;
  logic             win_cycle;

  // Two's-complement trick isolates the lowest set claim bit.
  assign pick_low  = ply_req & (~ply_req + 1'b1);
  assign timer_hit = (TIMEOUT != 0) && (timer_reg == T_LAST);
  assign win_cycle = (state_reg == S_EVAL) && adder;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      mask_reg    <= '0;
      verify_reg  <= '0;
      miss_reg    <= '0;
      timeout_reg <= 1'b0;
      timer_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      mask_reg    <= mask_next;
      verify_reg  <= verify_next;
      miss_reg    <= miss_next;
      timeout_reg <= timeout_next;
      timer_reg   <= timer_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mask_next    = mask_reg;
    verify_next  = '0;
    miss_next    = '0;
    timeout_next = 1'b0;
    timer_next   = timer_reg;
    case (state_reg)
      S_IDLE: begin
        if (|ply_req) begin
          mask_next  = (MULTI_WIN != 0) ? ply_req : pick_low;
          state_next = S_EVAL;
        end
      end
      S_EVAL: begin
        if (adder) begin
          verify_next = mask_reg;
          state_next  = S_IDLE;
        end else begin
          miss_next  = mask_reg;
          timer_next = '0;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        // A fresh number always ends the hold, even on the timeout cycle.
        if (rng) begin
          state_next = S_IDLE;
        end else if (timer_hit) begin
          timeout_next = 1'b1;
          state_next   = S_IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_PLY; gi++) begin : g_score
      sat_counter #(.W(SCORE_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (score_clr),
        .inc (win_cycle && mask_reg[gi]),
        .q   (score[gi*SCORE_W +: SCORE_W])
      );
    end
  endgenerate

  assign verify_out = verify_reg;
  assign miss_out   = miss_reg;
  assign timeout    = timeout_reg;
  assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_prime_verify_multi.sv
// Bench for prime_verify_multi: directed table, corner sequences and random
// stimulus against a round-level reference model (MULTI_WIN=1 and 0 copies).
module tb_prime_verify_multi;

  localparam int N  = 2;
  localparam int SW = 4;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rng = 1'b0;
  logic         adder = 1'b0;
  logic         score_clr = 1'b0;
  logic [N-1:0] ply_req = '0;

  logic [N-1:0]    v0, m0, v1, m1;
  logic            to0, to1, b0, b1;
  logic [N*SW-1:0] s0, s1;

  always #5 clk = ~clk;

  prime_verify_multi #(.N_PLY(N), .SCORE_W(SW), .TIMEOUT(TO), .MULTI_WIN(1)) dut_multi (
    .clk(clk), .rst(rst), .rng(rng), .ply_req(ply_req), .adder(adder),
    .score_clr(score_clr), .verify_out(v0), .miss_out(m0), .timeout(to0),
    .busy(b0), .score(s0)
  );

  prime_verify_multi #(.N_PLY(N), .SCORE_W(SW), .TIMEOUT(TO), .MULTI_WIN(0)) dut_single (
    .clk(clk), .rst(rst), .rng(rng), .ply_req(ply_req), .adder(adder),
    .score_clr(score_clr), .verify_out(v1), .miss_out(m1), .timeout(to1),
    .busy(b1), .score(s1)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: round phase (0 idle, 1 judging, 2 waiting), per-player scores.
  int         m_phase [2];
  logic [1:0] m_mask  [2];
  int         m_cnt   [2];
  int         m_sc    [2][2];
  logic [1:0] e_v     [2];
  logic [1:0] e_m     [2];
  logic       e_to    [2];

  task automatic model_step(input int k, input bit multi);
    e_v[k]  = 2'b00;
    e_m[k]  = 2'b00;
    e_to[k] = 1'b0;
    if (!rst) begin
      m_phase[k] = 0;
      m_mask[k]  = 2'b00;
      m_cnt[k]   = 0;
      m_sc[k][0] = 0;
      m_sc[k][1] = 0;
    end else begin
      case (m_phase[k])
        0: if (ply_req != 2'b00) begin
          m_mask[k]  = (!multi && ply_req[0]) ? 2'b01 : ply_req;
          m_phase[k] = 1;
        end
        1: begin
          if (adder) begin
            e_v[k] = m_mask[k];
            for (int p = 0; p < N; p++)
              if (m_mask[k][p] && m_sc[k][p] < (2**SW - 1)) m_sc[k][p] = m_sc[k][p] + 1;
            m_phase[k] = 0;
          end else begin
            e_m[k]     = m_mask[k];
            m_cnt[k]   = 0;
            m_phase[k] = 2;
          end
        end
        default: begin
          m_cnt[k] = m_cnt[k] + 1;
          if (rng) m_phase[k] = 0;
          else if (TO != 0 && m_cnt[k] == TO) begin
            e_to[k]    = 1'b1;
            m_phase[k] = 0;
          end
        end
      endcase
      if (score_clr) begin
        m_sc[k][0] = 0;
        m_sc[k][1] = 0;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    chk("verify_multi",  int'(v0),  int'(e_v[0]));
    chk("miss_multi",    int'(m0),  int'(e_m[0]));
    chk("timeout_multi", int'(to0), int'(e_to[0]));
    chk("busy_multi",    int'(b0),  int'(m_phase[0] != 0));
    chk("score_multi",   int'(s0),  m_sc[0][1] * 16 + m_sc[0][0]);
    chk("verify_single", int'(v1),  int'(e_v[1]));
    chk("miss_single",   int'(m1),  int'(e_m[1]));
    chk("timeout_single",int'(to1), int'(e_to[1]));
    chk("busy_single",   int'(b1),  int'(m_phase[1] != 0));
    chk("score_single",  int'(s1),  m_sc[1][1] * 16 + m_sc[1][0]);
  endtask

  typedef struct {
    bit         rst_n;
    bit         rng;
    logic [1:0] req;
    bit         add;
    bit         clr;
    logic [1:0] v;
    logic [1:0] m;
    bit         to;
    bit         busy;
  } vec_t;

  vec_t tbl [17];
  int   found;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_mask[k] = 0; m_cnt[k] = 0;
      m_sc[k][0] = 0; m_sc[k][1] = 0;
    end
    //            rst rng req    add clr   v      m      to busy
    tbl[0]  = '{0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0};
    tbl[1]  = '{1, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0, 1};
    tbl[2]  = '{1, 0, 2'b00, 1, 0, 2'b01, 2'b00, 0, 0};
    tbl[3]  = '{1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0};
    tbl[4]  = '{1, 0, 2'b11, 0, 0, 2'b00, 2'b00, 0, 1};
    tbl[5]  = '{1, 0, 2'b00, 1, 0, 2'b11, 2'b00, 0, 0};
    tbl[6]  = '{1, 0, 2'b10, 0, 0, 2'b00, 2'b00, 0, 1};
    tbl[7]  = '{1, 0, 2'b00, 0, 0, 2'b00, 2'b10, 0, 1};
    tbl[8]  = '{1, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0, 1};
    tbl[9]  = '{1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1};
    tbl[10] = '{1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0};
    tbl[11] = '{1, 0, 2'b01, 0, 0, 2'b00, 2'b00, 0, 1};
    tbl[12] = '{1, 0, 2'b00, 1, 0, 2'b01, 2'b00, 0, 0};
    tbl[13] = '{1, 1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0};
    tbl[14] = '{1, 0, 2'b10, 0, 0, 2'b00, 2'b00, 0, 1};
    tbl[15] = '{1, 0, 2'b00, 0, 0, 2'b00, 2'b10, 0, 1};
    tbl[16] = '{0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0};

    for (int i = 0; i < 17; i++) begin
      rst = tbl[i].rst_n; rng = tbl[i].rng; ply_req = tbl[i].req;
      adder = tbl[i].add; score_clr = tbl[i].clr;
      step();
      chk("tbl_verify",  int'(v0),  int'(tbl[i].v));
      chk("tbl_miss",    int'(m0),  int'(tbl[i].m));
      chk("tbl_timeout", int'(to0), int'(tbl[i].to));
      chk("tbl_busy",    int'(b0),  int'(tbl[i].busy));
      if (i == 5)  chk("single_pick_verify", int'(v1), 1);
      if (i == 12) chk("tbl_score_multi",  int'(s0), 8'h13);
      if (i == 12) chk("tbl_score_single", int'(s1), 8'h03);
      if (i == 16) chk("reset_scores", int'(s0), 0);
    end
    rst = 1'b1; rng = 1'b0; ply_req = '0; adder = 1'b0; score_clr = 1'b0;

    // Saturation: 16 straight wins by player 0.
    for (int w = 0; w < 16; w++) begin
      ply_req = 2'b01; step();
      ply_req = 2'b00; adder = 1'b1; step();
      adder = 1'b0;
    end
    chk("score_saturate", int'(s0[3:0]), 15);

    // Clear lands on the same edge as a win: clear wins.
    ply_req = 2'b01; step();
    ply_req = 2'b00; adder = 1'b1; score_clr = 1'b1; step();
    chk("clr_win_verify", int'(v0), 1);
    chk("clr_win_score",  int'(s0[3:0]), 0);
    adder = 1'b0; score_clr = 1'b0;

    // Timeout with claims held during HOLD.
    ply_req = 2'b01; step();
    ply_req = 2'b00; step();
    ply_req = 2'b11;
    found = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (to0) begin
        found = i;
        break;
      end
    end
    chk("timeout_delay", found, TO);
    ply_req = 2'b00; step();
    chk("idle_after_timeout", int'(b0), 0);

    // rng and timeout on the same edge: rng wins, no timeout pulse.
    ply_req = 2'b01; step();
    ply_req = 2'b00; step();
    repeat (TO - 1) step();
    rng = 1'b1; step();
    chk("rng_vs_timeout_pulse", int'(to0), 0);
    chk("rng_vs_timeout_busy",  int'(b0), 0);
    rng = 1'b0;

    // Reset in the middle of HOLD.
    ply_req = 2'b10; step();
    ply_req = 2'b00; step();
    step();
    rst = 1'b0; step();
    chk("rst_hold_busy",  int'(b0), 0);
    chk("rst_hold_score", int'(s0), 0);
    rst = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 99) != 0);
      rng       = ($urandom_range(0, 7) == 0);
      ply_req   = ($urandom_range(0, 2) == 0) ? 2'(($urandom_range(1, 3))) : 2'b00;
      adder     = ($urandom_range(0, 2) != 0);
      score_clr = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
